// File: rtl/imm_decode_stage.sv
// imm_decode_stage: IF/ID pipeline register with registered immediate-format decode.
// Revision 1.0 - initial release.
`default_nettype none

module imm_decode_stage #(
   parameter int          DATA_WIDTH = 32,
   parameter logic [31:0] NOP_INSTR  = 32'h00000013
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [31:0]           InstrF,
   input  logic [DATA_WIDTH-1:0] PCF,
   input  logic [DATA_WIDTH-1:0] PCPlus4F,
   input  logic                  ValidF,
   input  logic                  StallD,
   input  logic                  FlushD,
   output logic [24:0]           ImmediateD,
   output logic [2:0]            ImmSrcD,
   output logic [4:0]            Rs1D,
   output logic [4:0]            Rs2D,
   output logic [4:0]            RdD,
   output logic [DATA_WIDTH-1:0] PCD,
   output logic [DATA_WIDTH-1:0] PCPlus4D,
   output logic                  ValidD,
   output logic                  IllegalD
);

   localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
   localparam logic [6:0] c_OP_IMM    = 7'b0010011;
   localparam logic [6:0] c_OP_JALR   = 7'b1100111;
   localparam logic [6:0] c_OP_STORE  = 7'b0100011;
   localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
   localparam logic [6:0] c_OP_JAL    = 7'b1101111;
   localparam logic [6:0] c_OP_LUI    = 7'b0110111;
   localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] c_OP_REG    = 7'b0110011;

   localparam logic [2:0] c_IMM_I = 3'b000;
   localparam logic [2:0] c_IMM_S = 3'b001;
   localparam logic [2:0] c_IMM_B = 3'b010;
   localparam logic [2:0] c_IMM_J = 3'b011;
   localparam logic [2:0] c_IMM_U = 3'b100;

   logic [31:0]           instr_q,   instr_d;
   logic [2:0]            imm_src_q, imm_src_d;
   logic [DATA_WIDTH-1:0] pc_q,      pc_d;
   logic [DATA_WIDTH-1:0] pc4_q,     pc4_d;
   logic                  valid_q,   valid_d;
   logic                  illegal_q, illegal_d;

   logic [2:0]            w_imm_src;
   logic                  w_unsupported;

   always_comb begin
      w_imm_src     = c_IMM_I;
      w_unsupported = 1'b0;
      case (InstrF[6:0])
         c_OP_LOAD, c_OP_IMM, c_OP_JALR, c_OP_REG: w_imm_src = c_IMM_I;
         c_OP_STORE:                               w_imm_src = c_IMM_S;
         c_OP_BRANCH:                              w_imm_src = c_IMM_B;
         c_OP_JAL:                                 w_imm_src = c_IMM_J;
         c_OP_LUI, c_OP_AUIPC:                     w_imm_src = c_IMM_U;
         default:                                  w_unsupported = 1'b1;
      endcase
   end

   // Flush outranks stall so a squashed instruction cannot linger behind a stall.
   always_comb begin
      instr_d   = instr_q;
      imm_src_d = imm_src_q;
      pc_d      = pc_q;
      pc4_d     = pc4_q;
      valid_d   = valid_q;
      illegal_d = illegal_q;
      if (FlushD) begin
         instr_d   = NOP_INSTR;
         imm_src_d = c_IMM_I;
         pc_d      = '0;
         pc4_d     = '0;
         valid_d   = 1'b0;
         illegal_d = 1'b0;
      end else if (!StallD) begin
         instr_d   = InstrF;
         imm_src_d = w_imm_src;
         pc_d      = PCF;
         pc4_d     = PCPlus4F;
         valid_d   = ValidF;
         illegal_d = ValidF & w_unsupported;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr_q   <= NOP_INSTR;
         imm_src_q <= c_IMM_I;
         pc_q      <= '0;
         pc4_q     <= '0;
         valid_q   <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         instr_q   <= instr_d;
         imm_src_q <= imm_src_d;
         pc_q      <= pc_d;
         pc4_q     <= pc4_d;
         valid_q   <= valid_d;
         illegal_q <= illegal_d;
      end
   end

   assign ImmediateD = instr_q[31:7];
   assign Rs1D       = instr_q[19:15];
   assign Rs2D       = instr_q[24:20];
   assign RdD        = instr_q[11:7];
   assign ImmSrcD    = imm_src_q;
   assign PCD        = pc_q;
   assign PCPlus4D   = pc4_q;
   assign ValidD     = valid_q;
   assign IllegalD   = illegal_q & valid_q;

endmodule

`default_nettype wire

// File: tb/tb_imm_decode_stage.sv
// tb_imm_decode_stage: directed-vector bench for imm_decode_stage.
// Revision 1.0 - initial release.
`default_nettype none

module tb_imm_decode_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] InstrF;
   logic [31:0] PCF;
   logic [31:0] PCPlus4F;
   logic        ValidF;
   logic        StallD;
   logic        FlushD;
   logic [24:0] ImmediateD;
   logic [2:0]  ImmSrcD;
   logic [4:0]  Rs1D, Rs2D, RdD;
   logic [31:0] PCD, PCPlus4D;
   logic        ValidD;
   logic        IllegalD;

   int vectors     = 0;
   int miscompares = 0;

   imm_decode_stage #(
      .DATA_WIDTH (32),
      .NOP_INSTR  (32'h00000013)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .InstrF     (InstrF),
      .PCF        (PCF),
      .PCPlus4F   (PCPlus4F),
      .ValidF     (ValidF),
      .StallD     (StallD),
      .FlushD     (FlushD),
      .ImmediateD (ImmediateD),
      .ImmSrcD    (ImmSrcD),
      .Rs1D       (Rs1D),
      .Rs2D       (Rs2D),
      .RdD        (RdD),
      .PCD        (PCD),
      .PCPlus4D   (PCPlus4D),
      .ValidD     (ValidD),
      .IllegalD   (IllegalD)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                        input logic valid, input logic stall, input logic flush);
      @(negedge clk);
      InstrF   = instr;
      PCF      = pc;
      PCPlus4F = pc + 32'd4;
      ValidF   = valid;
      StallD   = stall;
      FlushD   = flush;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; InstrF = '0; PCF = '0; PCPlus4F = '0;
      ValidF = 1'b0; StallD = 1'b0; FlushD = 1'b1;
      tick();
      chk("rst_valid",  ValidD,     0);
      chk("rst_imm",    ImmediateD, 25'h0);
      chk("rst_pcd",    PCD,        0);

      // Load one real instruction, then pull reset between edges.
      drive(32'h00C58623, 32'h100, 1'b1, 1'b0, 1'b0);
      rst_n = 1'b1;
      tick();
      chk("pre_rst_valid", ValidD, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_valid",  ValidD,     0);
      chk("async_rst_immsrc", ImmSrcD,    3'b000);
      chk("async_rst_imm",    ImmediateD, 25'h0);
      chk("async_rst_rd",     RdD,        0);
      chk("async_rst_rs1",    Rs1D,       0);
      chk("async_rst_rs2",    Rs2D,       0);
      chk("async_rst_pcd",    PCD,        0);
      chk("async_rst_pc4d",   PCPlus4D,   0);
      chk("async_rst_ill",    IllegalD,   0);

      // Decode sweep: sb, beq, jal, lui.
      drive(32'h00C58623, 32'h100, 1'b1, 1'b0, 1'b0);
      rst_n = 1'b1;
      tick();
      chk("sb_immsrc", ImmSrcD,    3'b001);
      chk("sb_imm",    ImmediateD, 25'h0018B0C);
      chk("sb_rs1",    Rs1D,       5'd11);
      chk("sb_rs2",    Rs2D,       5'd12);
      chk("sb_pcd",    PCD,        32'h100);
      chk("sb_pc4d",   PCPlus4D,   32'h104);
      chk("sb_valid",  ValidD,     1);
      drive(32'hFE0008E3, 32'h104, 1'b1, 1'b0, 1'b0);
      tick();
      chk("beq_immsrc", ImmSrcD,    3'b010);
      chk("beq_imm",    ImmediateD, 25'h1FC0011);
      chk("beq_pcd",    PCD,        32'h104);
      drive(32'h004000EF, 32'h108, 1'b1, 1'b0, 1'b0);
      tick();
      chk("jal_immsrc", ImmSrcD,    3'b011);
      chk("jal_rd",     RdD,        5'd1);
      chk("jal_pcd",    PCD,        32'h108);
      drive(32'h123452B7, 32'h10C, 1'b1, 1'b0, 1'b0);
      tick();
      chk("lui_immsrc", ImmSrcD,    3'b100);
      chk("lui_imm",    ImmediateD, 25'h02468A5);
      chk("lui_rd",     RdD,        5'd5);
      chk("lui_pcd",    PCD,        32'h10C);

      // Other I-type / U-type opcodes.
      drive(32'h0000A103, 32'h110, 1'b1, 1'b0, 1'b0);
      tick();
      chk("lw_immsrc", ImmSrcD, 3'b000);
      drive(32'h00000297, 32'h114, 1'b1, 1'b0, 1'b0);
      tick();
      chk("auipc_immsrc", ImmSrcD, 3'b100);
      drive(32'h000080E7, 32'h118, 1'b1, 1'b0, 1'b0);
      tick();
      chk("jalr_immsrc", ImmSrcD, 3'b000);
      chk("jalr_ill",    IllegalD, 0);

      // Stall: addi x1,x0,5 held for three cycles while InstrF changes.
      drive(32'h00500093, 32'h10, 1'b1, 1'b0, 1'b0);
      tick();
      chk("addi_imm", ImmediateD, 25'h000A001);
      for (int i = 0; i < 3; i++) begin
         drive(32'hFE0008E3 + i, 32'h40 + i, i[0], 1'b1, 1'b0);
         tick();
         chk("stall_imm",    ImmediateD, 25'h000A001);
         chk("stall_immsrc", ImmSrcD,    3'b000);
         chk("stall_rd",     RdD,        5'd1);
         chk("stall_pcd",    PCD,        32'h10);
         chk("stall_pc4d",   PCPlus4D,   32'h14);
         chk("stall_valid",  ValidD,     1);
      end
      drive(32'h004000EF, 32'h20, 1'b1, 1'b0, 1'b0);
      tick();
      chk("resume_immsrc", ImmSrcD, 3'b011);
      chk("resume_pcd",    PCD,     32'h20);

      // Flush wins over stall.
      drive(32'h00C58623, 32'h24, 1'b1, 1'b1, 1'b1);
      tick();
      chk("flush_valid",  ValidD,     0);
      chk("flush_immsrc", ImmSrcD,    3'b000);
      chk("flush_rd",     RdD,        0);
      chk("flush_pcd",    PCD,        0);
      chk("flush_pc4d",   PCPlus4D,   0);
      chk("flush_imm",    ImmediateD, 25'h0);

      // Illegal opcode, valid and bubble; R-type is legal.
      drive(32'h0000007F, 32'h30, 1'b1, 1'b0, 1'b0);
      tick();
      chk("ill_flag",   IllegalD, 1);
      chk("ill_immsrc", ImmSrcD,  3'b000);
      chk("ill_valid",  ValidD,   1);
      drive(32'h0000007F, 32'h34, 1'b0, 1'b0, 1'b0);
      tick();
      chk("ill_bubble_flag",  IllegalD, 0);
      chk("ill_bubble_valid", ValidD,   0);
      drive(32'h00B50533, 32'h38, 1'b1, 1'b0, 1'b0);
      tick();
      chk("add_ill",    IllegalD, 0);
      chk("add_immsrc", ImmSrcD,  3'b000);

      // Bubble carrying an S-type word.
      drive(32'h00C58623, 32'h3C, 1'b0, 1'b0, 1'b0);
      tick();
      chk("bubble_valid",  ValidD,   0);
      chk("bubble_immsrc", ImmSrcD,  3'b001);
      chk("bubble_ill",    IllegalD, 0);
      chk("bubble_pcd",    PCD,      32'h3C);

      // Reset during a stall discards the held instruction.
      drive(32'h004000EF, 32'h50, 1'b1, 1'b0, 1'b0);
      tick();
      drive(32'h00C58623, 32'h54, 1'b1, 1'b1, 1'b0);
      tick();
      chk("pre_rst_stall_rd", RdD, 5'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_stall_valid",  ValidD,  0);
      chk("rst_stall_immsrc", ImmSrcD, 3'b000);
      chk("rst_stall_rd",     RdD,     0);
      chk("rst_stall_pcd",    PCD,     0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("post_rst_stall_valid", ValidD, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/imm_decode_stage.md
IMM_DECODE_STAGE -- requirements
Module: imm_decode_stage

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the width of the PC and PCPlus4 paths.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h00000013, the instruction word loaded on reset and on flush (addi x0,x0,0).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 InstrF  input  32  fetched instruction word.
REQ-006 PCF  input  DATA_WIDTH  PC of InstrF.
REQ-007 PCPlus4F  input  DATA_WIDTH  PCF+4 from fetch.
REQ-008 ValidF  input  1  InstrF/PCF/PCPlus4F hold a real instruction this cycle.
REQ-009 StallD  input  1  hold all stage registers.
REQ-010 FlushD  input  1  replace stage contents with a bubble.
REQ-011 ImmediateD  output  25  InstrD[31:7], the field consumed by the sign extender.
REQ-012 ImmSrcD  output  3  immediate format select for the sign extender.
REQ-013 Rs1D, Rs2D, RdD  output  5 each  InstrD[19:15], InstrD[24:20], InstrD[11:7].
REQ-014 PCD, PCPlus4D  output  DATA_WIDTH each  registered PCF and PCPlus4F.
REQ-015 ValidD  output  1  stage holds a real instruction.
REQ-016 IllegalD  output  1  the held opcode is unsupported; asserted only when ValidD=1.

Function
REQ-017 SHALL decode ImmSrc from InstrF[6:0] combinationally and register the result alongside InstrF, so ImmSrcD always matches the held instruction (latency 1 cycle, InstrF to ImmSrcD).
REQ-018 Opcode map:
- 0000011, 0010011, 1100111 -> 000 (I-type)
- 0100011 -> 001 (S-type)
- 1100011 -> 010 (B-type)
- 1101111 -> 011 (J-type)
- 0110111, 0010111 -> 100 (U-type)
- 0110011 -> 000, not illegal
- any other opcode -> 000, illegal
REQ-019 Each edge, priority FlushD > StallD > load.
REQ-020 Flush: InstrD=NOP_INSTR, ImmSrcD=000, PCD=0, PCPlus4D=0, ValidD=0, illegal flag=0; applies even when StallD=1.
REQ-021 Stall (FlushD=0): every stage register holds its value; InstrF and ValidF are ignored.
REQ-022 Load (FlushD=0, StallD=0): capture InstrF, decoded ImmSrc, PCF, PCPlus4F and ValidF, plus the illegal flag = ValidF AND opcode unsupported.
REQ-023 ValidF=0 on load: capture all fields as given, ValidD=0, IllegalD=0.
REQ-024 IllegalD SHALL equal the registered illegal flag AND ValidD.
REQ-025 ImmediateD, Rs1D, Rs2D and RdD SHALL be pure slices of the registered InstrD, with no further logic.

Reset
REQ-026 rst_n low SHALL immediately, without waiting for a clock edge, force:
- InstrD=NOP_INSTR, so ImmediateD=25'h0000000, Rs1D=Rs2D=RdD=0
- ImmSrcD=000, PCD=0, PCPlus4D=0
- ValidD=0, IllegalD=0
REQ-027 Reset SHALL override FlushD and StallD; the first load SHALL happen at the first rising edge with rst_n high.
REQ-028 Reset asserted mid-stall SHALL discard the held instruction.

Verification
REQ-029 Reset: assert rst_n=0 between edges -> outputs take the REQ-026 values before the next edge; ValidD=0.
REQ-030 Decode sweep: load InstrF=32'h00C58623 (sb), then 32'hFE0008E3 (beq), then 32'h004000EF (jal), then 32'h123452B7 (lui), all with ValidF=1 -> ImmSrcD=001, 010, 011, 100 on successive cycles; ImmediateD=InstrF[31:7]; PCD tracks PCF.
REQ-031 Stall: load 32'h00500093 at PCF=0x10, then hold StallD=1 for 3 cycles while InstrF changes -> InstrD-derived outputs, PCD=0x10 and ValidD=1 stay unchanged; resume after StallD drops.
REQ-032 Flush with stall: StallD=1 and FlushD=1 on the same edge -> ValidD=0, ImmSrcD=000, RdD=0, PCD=0.
REQ-033 Illegal: InstrF=32'h0000007F with ValidF=1 -> IllegalD=1, ImmSrcD=000; same word with ValidF=0 -> IllegalD=0.
REQ-034 Bubble: ValidF=0 with InstrF=32'h00C58623 -> ValidD=0, ImmSrcD=001, IllegalD=0.
